// File: rtl/can_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : can_pkg                                                |
// | Description : Shared constants and state encoding for the CAN bit    |
// |               stuffing engine.                                       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package can_pkg;

   // Classic CAN inserts a stuff bit after five equal bits.
   localparam int STUFF_LEN_CLASSIC = 5;
   // CAN FD CRC field carries a fixed stuff bit after every four data bits.
   localparam int FIXED_LEN_FD      = 4;
   // Width of the dynamic stuff counter reported alongside the CRC.
   localparam int STUFF_CNT_W       = 3;

   typedef enum logic [1:0] {
      OFF = 2'd0,
      DYN = 2'd1,
      FIX = 2'd2
   } stuff_state_e;

endpackage
`default_nettype wire

// File: rtl/can_stuff_cnt_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : can_stuff_cnt_enc                                      |
// | Description : Binary to gray conversion of the stuff count plus the  |
// |               even parity over the gray bits. Purely combinational.  |
// | Ports       : bin    - binary stuff count                            |
// |               gray   - gray-coded stuff count                        |
// |               parity - XOR of all gray bits                          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module can_stuff_cnt_enc
   import can_pkg::*;
#(
   parameter int CNT_W = STUFF_CNT_W
) (
   input  logic [CNT_W-1:0] bin,
   output logic [CNT_W-1:0] gray,
   output logic             parity
);

   assign gray   = bin ^ (bin >> 1);
   assign parity = ^gray;

endmodule
`default_nettype wire

// File: rtl/can_stuff_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : can_stuff_engine                                       |
// | Description : CAN bit stuffing (TX) / destuffing (RX) engine with    |
// |               dynamic (run-length) and fixed (CAN FD CRC) stuffing,  |
// |               stuff error detection and a gray-coded stuff counter.  |
// | Ports       : clk, rst_n (async, active-low), reset_mode (sync)      |
// |               mode_rx          0=TX stuff, 1=RX destuff              |
// |               stuff_en/fixed_en stuffing mode select                 |
// |               bit_start_point  TX strobe, sample_point RX strobe     |
// |               tx_bit_in/tx_bit_ready/tx_bit_out  TX bit path         |
// |               rx_bit_in/rx_bit_valid/rx_bit_out  RX bit path         |
// |               stuff_bit_flag, stuff_err  one-cycle status pulses     |
// |               cnt_clr, stuff_cnt_gray, stuff_parity  stuff counter   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module can_stuff_engine
   import can_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_CLASSIC,
   parameter int FIXED_LEN = FIXED_LEN_FD,
   parameter int CNT_W     = STUFF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reset_mode,
   input  logic             mode_rx,
   input  logic             stuff_en,
   input  logic             fixed_en,
   input  logic             bit_start_point,
   input  logic             sample_point,
   input  logic             tx_bit_in,
   output logic             tx_bit_ready,
   output logic             tx_bit_out,
   input  logic             rx_bit_in,
   output logic             rx_bit_valid,
   output logic             rx_bit_out,
   output logic             stuff_bit_flag,
   output logic             stuff_err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] stuff_cnt_gray,
   output logic             stuff_parity
);

   localparam int RUN_W = $clog2(STUFF_LEN + 1);
   localparam int FIX_W = $clog2(FIXED_LEN + 1);

   stuff_state_e     state_q, state_d, state_eff;
   logic             last_bit_q, last_bit_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [FIX_W-1:0] fix_cnt_q, fix_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_bit_out_q, tx_bit_out_d;
   logic             rx_bit_valid_q, rx_bit_valid_d;
   logic             rx_bit_out_q, rx_bit_out_d;
   logic             stuff_flag_q, stuff_flag_d;
   logic             stuff_err_q, stuff_err_d;

   logic             strobe;
   logic             bus_bit;
   logic             is_stuff;
   logic             stuff_val;

   // Strobe decode and stuff-position decision for the current bit.
   always_comb begin
      strobe    = mode_rx ? sample_point : bit_start_point;
      bus_bit   = mode_rx ? rx_bit_in : tx_bit_in;
      stuff_val = ~last_bit_q;

      if (fixed_en) begin
         state_eff = FIX;
      end else if (stuff_en) begin
         state_eff = DYN;
      end else begin
         state_eff = OFF;
      end

      // The enables are sampled at the strobe itself, so the decision uses
      // the freshly decoded state; state_q only tells us whether FIX is new.
      is_stuff = 1'b0;
      case (state_eff)
         DYN:     is_stuff = (run_q == RUN_W'(STUFF_LEN));
         FIX:     is_stuff = (state_q != FIX) || (fix_cnt_q == FIX_W'(FIXED_LEN));
         default: is_stuff = 1'b0;
      endcase

      tx_bit_ready = strobe && !mode_rx && !reset_mode && !is_stuff;
   end

   // Next-state logic for the mode FSM and all bit-level state.
   always_comb begin
      state_d        = state_q;
      last_bit_d     = last_bit_q;
      run_d          = run_q;
      fix_cnt_d      = fix_cnt_q;
      cnt_d          = cnt_q;
      tx_bit_out_d   = tx_bit_out_q;
      rx_bit_valid_d = 1'b0;
      rx_bit_out_d   = rx_bit_out_q;
      stuff_flag_d   = 1'b0;
      stuff_err_d    = 1'b0;

      if (strobe) begin
         state_d = state_eff;
         if (is_stuff) begin
            last_bit_d   = stuff_val;
            run_d        = RUN_W'(1);
            fix_cnt_d    = '0;
            stuff_flag_d = 1'b1;
            if (mode_rx) begin
               // A received stuff bit must differ from the preceding bit.
               stuff_err_d = (rx_bit_in == last_bit_q);
            end else begin
               tx_bit_out_d = stuff_val;
            end
            if (state_eff == DYN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            last_bit_d = bus_bit;
            if (mode_rx) begin
               rx_bit_valid_d = 1'b1;
               rx_bit_out_d   = bus_bit;
            end else begin
               tx_bit_out_d = bus_bit;
            end
            // OFF and FIX keep run parked at 1 so that entering DYN from
            // either starts a fresh run; leaving FIX drops its bit count.
            case (state_eff)
               DYN: begin
                  run_d     = (bus_bit == last_bit_q) ? run_q + RUN_W'(1) : RUN_W'(1);
                  fix_cnt_d = '0;
               end
               FIX: begin
                  run_d     = RUN_W'(1);
                  fix_cnt_d = fix_cnt_q + FIX_W'(1);
               end
               default: begin
                  run_d     = RUN_W'(1);
                  fix_cnt_d = '0;
               end
            endcase
         end
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end

      if (reset_mode) begin
         state_d        = OFF;
         last_bit_d     = 1'b1;
         run_d          = RUN_W'(1);
         fix_cnt_d      = '0;
         cnt_d          = '0;
         tx_bit_out_d   = 1'b1;
         rx_bit_valid_d = 1'b0;
         rx_bit_out_d   = 1'b1;
         stuff_flag_d   = 1'b0;
         stuff_err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= OFF;
         last_bit_q     <= 1'b1;
         run_q          <= RUN_W'(1);
         fix_cnt_q      <= '0;
         cnt_q          <= '0;
         tx_bit_out_q   <= 1'b1;
         rx_bit_valid_q <= 1'b0;
         rx_bit_out_q   <= 1'b1;
         stuff_flag_q   <= 1'b0;
         stuff_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_bit_q     <= last_bit_d;
         run_q          <= run_d;
         fix_cnt_q      <= fix_cnt_d;
         cnt_q          <= cnt_d;
         tx_bit_out_q   <= tx_bit_out_d;
         rx_bit_valid_q <= rx_bit_valid_d;
         rx_bit_out_q   <= rx_bit_out_d;
         stuff_flag_q   <= stuff_flag_d;
         stuff_err_q    <= stuff_err_d;
      end
   end

   assign tx_bit_out     = tx_bit_out_q;
   assign rx_bit_valid   = rx_bit_valid_q;
   assign rx_bit_out     = rx_bit_out_q;
   assign stuff_bit_flag = stuff_flag_q;
   assign stuff_err      = stuff_err_q;

   can_stuff_cnt_enc #(
      .CNT_W (CNT_W)
   ) u_cnt_enc (
      .bin    (cnt_q),
      .gray   (stuff_cnt_gray),
      .parity (stuff_parity)
   );

endmodule
`default_nettype wire

// File: doc/can_stuff_engine.md
CAN_STUFF_ENGINE -- requirements
Module: can_stuff_engine

Interface
REQ-001 SHALL have parameter STUFF_LEN, default 5, equal-bit run length that triggers a dynamic stuff bit.
REQ-002 SHALL have parameter FIXED_LEN, default 4, data bits between fixed stuff bits.
REQ-003 SHALL have parameter CNT_W, default 3, stuff counter width.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port reset_mode  in  1  synchronous soft reset.
REQ-007 SHALL have port mode_rx  in  1  0=TX stuffing, 1=RX destuffing.
REQ-008 SHALL have port stuff_en  in  1  dynamic stuffing enable.
REQ-009 SHALL have port fixed_en  in  1  fixed stuffing enable; overrides stuff_en.
REQ-010 SHALL have port bit_start_point  in  1  TX bit-boundary strobe.
REQ-011 SHALL have port sample_point  in  1  RX sample strobe.
REQ-012 SHALL have port tx_bit_in  in  1  raw bit from TX FSM.
REQ-013 SHALL have port tx_bit_ready  out  1  combinational; raw bit consumed this bit_start_point.
REQ-014 SHALL have port tx_bit_out  out  1  registered bus bit.
REQ-015 SHALL have port rx_bit_in  in  1  sampled bus bit.
REQ-016 SHALL have port rx_bit_valid  out  1  one-cycle pulse, destuffed bit available.
REQ-017 SHALL have port rx_bit_out  out  1  destuffed bit, qualified by rx_bit_valid.
REQ-018 SHALL have port stuff_bit_flag  out  1  one-cycle pulse, a stuff bit was sent or removed.
REQ-019 SHALL have port stuff_err  out  1  one-cycle pulse, RX stuff rule violated.
REQ-020 SHALL have port cnt_clr  in  1  clears stuff counter.
REQ-021 SHALL have ports stuff_cnt_gray  out  CNT_W, and stuff_parity  out  1: gray-coded dynamic stuff count and its even parity.

Function
REQ-022 SHALL run an FSM with states OFF (both enables low), DYN (stuff_en and not fixed_en) and FIX (fixed_en); the state is re-evaluated on every strobe.
REQ-023 Active strobe SHALL be bit_start_point when mode_rx=0 and sample_point when mode_rx=1; all bit state updates only on the active strobe.
REQ-024 SHALL track last_bit (last bus bit) and run (1..STUFF_LEN) in DYN.
- Equal bit: run increments.
- Differing bit: run reloads to 1.
REQ-025 In DYN, when run==STUFF_LEN at a strobe, that bit position SHALL be a stuff bit equal to ~last_bit; afterwards run=1 and last_bit=stuff bit.
REQ-026 In FIX, the first strobe after entering FIX and every strobe following FIXED_LEN data bits SHALL be a stuff bit equal to ~last_bit, resetting the fixed counter to 0.
REQ-027 In TX, tx_bit_out SHALL load the stuff bit or tx_bit_in one clk after the strobe; tx_bit_ready SHALL be 1 on non-stuff strobes and 0 on stuff strobes.
REQ-028 In RX, a stuff position SHALL be discarded (rx_bit_valid stays 0); the other positions assert rx_bit_valid with rx_bit_out=rx_bit_in one clk after sample_point.
REQ-029 In RX, a stuff position where rx_bit_in==last_bit SHALL pulse stuff_err one clk after sample_point (DYN and FIX); run then reloads to 1.
REQ-030 stuff_bit_flag SHALL pulse one clk after every stuff position, including errored ones.
REQ-031 The stuff counter SHALL count DYN stuff positions modulo 2^CNT_W, wrap 7->0 silently; FIX stuff bits SHALL NOT count.
REQ-032 cnt_clr SHALL zero the counter; if it coincides with an increment, the clear SHALL win.
REQ-033 stuff_cnt_gray SHALL equal bin^(bin>>1); stuff_parity SHALL be the XOR of the gray bits (even parity).
REQ-034 In OFF, bits SHALL pass through unmodified (tx_bit_ready=1, rx_bit_valid pulses), last_bit SHALL still update, run SHALL hold 1, and there SHALL be no stuff or error.
REQ-035 A DYN->FIX switch SHALL discard the pending run; a FIX->DYN switch SHALL restart run at 1.

Reset
REQ-036 On rst_n low, asynchronously:
- tx_bit_out=1, last_bit=1, run=1.
- fixed counter=0, stuff counter=0.
- rx_bit_valid=0, rx_bit_out=1, stuff_bit_flag=0, stuff_err=0.
- state OFF.
REQ-037 reset_mode high SHALL force the same values synchronously, overriding any strobe in the same cycle, including mid-frame.

Structure
REQ-038 Package can_pkg SHALL hold the STUFF_LEN_CLASSIC=5, FIXED_LEN_FD=4 and STUFF_CNT_W=3 constants and the stuff_state_e enum (OFF, DYN, FIX).
REQ-039 Sub-module can_stuff_cnt_enc SHALL implement the binary-to-gray conversion plus parity, combinationally.

Verification
REQ-040 TX DYN: tx_bit_in 0,0,0,0,0,0 -> tx_bit_out 0,0,0,0,0,1,0; tx_bit_ready=0 on 6th strobe; stuff_cnt_gray=001, parity 1.
REQ-041 RX DYN: rx_bit_in 1,1,1,1,1,0,1 -> six rx_bit_valid pulses with 1,1,1,1,1,1; stuff_bit_flag on 6th sample; no stuff_err.
REQ-042 RX DYN: rx_bit_in 0 x6 -> stuff_err pulse one clk after 6th sample_point; no rx_bit_valid for 6th bit.
REQ-043 TX FIX with last_bit=1: tx_bit_in 1,0,1,0,0 -> tx_bit_out 0,1,0,1,0,1,0; stuff counter unchanged.
REQ-044 Eight DYN stuff bits from 0 -> counter wraps to 0, gray 000, parity 0; cnt_clr with a coincident increment -> 0.
REQ-045 reset_mode asserted at run=4 -> run=1, tx_bit_out=1 next clk; the following 4 equal bits produce no stuff bit.
